// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder.
//   op_e     : operation encoding carried on the sub input
//   flags_t  : status flags registered alongside the result
//   stages_f : number of pipeline stages for a WIDTH/SEG split
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    // A zero segment width yields zero stages so the config check can flag it.
    function automatic int unsigned stages_f(input int unsigned width, input int unsigned seg);
        return (seg == 0) ? 0 : width / seg;
    endfunction

endpackage

// File: rtl/adder_pipe_if.sv
// Valid/ready operand and result bus for adder_pipe.
//   master : drives operands (in_valid, a, b, cin, sub) and out_ready
//   slave  : the adder; drives in_ready and the result beat
//            (out_valid, sum, cout, ovf, zero)
interface adder_pipe_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface

// File: rtl/adder_seg.sv
// Combinational SEG-bit adder slice.
//   a, b, cin : segment operands and carry-in
//   sum, cout : segment result and carry-out
//   cmsb      : carry into the segment MSB (for signed overflow)
module adder_seg #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           cmsb
);

    localparam int unsigned W1 = SEG + 1;

    logic [SEG:0] full;

    assign full = W1'(a) + W1'(b) + W1'(cin);
    assign sum  = full[SEG-1:0];
    assign cout = full[SEG];
    // MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out directly
    assign cmsb = full[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/adder_pipe.sv
// Pipelined add/subtract, SEG bits per stage, carries rippling through
// stage registers; skew registers keep operands and partial results aligned.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : adder_pipe_if slave (operand beat in, result beat out)
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_pipe_if.slave bus
);

    localparam int unsigned STAGES = stages_f(WIDTH, SEG);

    if ((SEG == 0) || ((WIDTH % SEG) != 0)) begin : g_cfg_check
        $error("adder_pipe: WIDTH must be a non-zero integer multiple of SEG");
    end

    logic             en;
    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Final-stage combinational result, fed into the output registers
    logic [WIDTH-1:0] res_d;
    logic             res_v;
    logic             res_cout;
    logic             res_cmsb;
    flags_t           flags_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    flags_t           flags_q;

    // Subtract is a + ~b + 1; cin only matters for add
    assign op      = op_e'(bus.sub);
    assign b_eff   = (op == OP_SUB) ? ~bus.b : bus.b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : bus.cin;

    // Whole pipeline advances unless a result is waiting on downstream
    assign en           = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned CW = WIDTH - SEG * k;     // operand bits not yet consumed
        localparam int unsigned RW = SEG * (k + 1);       // result bits produced so far

        logic [CW-1:0]  a_cur;
        logic [CW-1:0]  b_cur;
        logic           c_cur;
        logic           v_cur;
        logic [SEG-1:0] seg_sum;
        logic           seg_cout;
        logic           seg_cmsb;
        logic [RW-1:0]  r_d;

        if (k == 0) begin : g_head
            assign a_cur = bus.a;
            assign b_cur = b_eff;
            assign c_cur = cin_eff;
            assign v_cur = bus.in_valid;
            assign r_d   = seg_sum;
        end else begin : g_tail
            assign a_cur = g_stage[k-1].g_skew.a_q;
            assign b_cur = g_stage[k-1].g_skew.b_q;
            assign c_cur = g_stage[k-1].g_skew.c_q;
            assign v_cur = g_stage[k-1].g_skew.v_q;
            assign r_d   = {seg_sum, g_stage[k-1].g_skew.r_q};
        end

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a    (a_cur[SEG-1:0]),
            .b    (b_cur[SEG-1:0]),
            .cin  (c_cur),
            .sum  (seg_sum),
            .cout (seg_cout),
            .cmsb (seg_cmsb)
        );

        if (k == STAGES - 1) begin : g_last
            assign res_d    = r_d;
            assign res_v    = v_cur;
            assign res_cout = seg_cout;
            assign res_cmsb = seg_cmsb;
        end else begin : g_skew
            // Carry plus skewed operand / partial-result registers for the next stage
            logic [CW-SEG-1:0] a_q;
            logic [CW-SEG-1:0] b_q;
            logic [RW-1:0]     r_q;
            logic              c_q;
            logic              v_q;
            logic              unused_cmsb;

            assign unused_cmsb = seg_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin : p_stage
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    r_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (en) begin
                    a_q <= a_cur[CW-1:SEG];
                    b_q <= b_cur[CW-1:SEG];
                    r_q <= r_d;
                    c_q <= seg_cout;
                    v_q <= v_cur;
                end
            end
        end
    end

    // Flags for the final word; overflow is carry-in vs carry-out of the MSB
    always_comb begin : p_flags
        flags_d      = '0;
        flags_d.cout = res_cout;
        flags_d.ovf  = res_cout ^ res_cmsb;
        flags_d.zero = (res_d == '0);
    end

    // Output register: result and flags only move when a valid beat lands
    always_ff @(posedge clk or negedge rst_n) begin : p_out
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            flags_q     <= '0;
        end else if (en) begin
            out_valid_q <= res_v;
            if (res_v) begin
                sum_q   <= res_d;
                flags_q <= flags_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = flags_q.cout;
    assign bus.ovf       = flags_q.ovf;
    assign bus.zero      = flags_q.zero;

endmodule
